// File: rtl/y_id_pipe_pkg.sv
// Shared decode definitions for the ID stage: opcode constants, immediate
// type codes and opcode classification helpers.
package y_id_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  function automatic imm_type_t imm_type_of(input logic [6:0] op);
    imm_type_t t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: t = IMM_I;
      OP_STORE:                            t = IMM_S;
      OP_BRANCH:                           t = IMM_B;
      OP_LUI, OP_AUIPC:                    t = IMM_U;
      OP_JAL:                              t = IMM_J;
      default:                             t = IMM_NONE;
    endcase
    return t;
  endfunction

  // rs1 is read by R-type and by every immediate format except U and J
  function automatic logic uses_rs1(input logic [6:0] op);
    imm_type_t t;
    t = imm_type_of(op);
    return (op == OP_R) || (t == IMM_I) || (t == IMM_S) || (t == IMM_B);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    imm_type_t t;
    t = imm_type_of(op);
    return (op == OP_R) || (t == IMM_S) || (t == IMM_B);
  endfunction

  // Stores and branches are the only known formats without a destination
  function automatic logic writes_rd(input logic [6:0] op);
    imm_type_t t;
    t = imm_type_of(op);
    return (op == OP_R) || (t == IMM_I) || (t == IMM_U) || (t == IMM_J);
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    return (op == OP_R) || (imm_type_of(op) != IMM_NONE);
  endfunction

endpackage

// File: rtl/y_id_pipe_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the opcode and
// sign-extends from ins[31] to the datapath width.
module y_id_pipe_imm_gen
  import y_id_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output logic [XLEN-1:0] imm,
  output imm_type_t       imm_type
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate for the detected format
  always_comb begin
    imm_type = imm_type_of(ins[6:0]);
    imm32    = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm32 = {ins[31:12], 12'h000};
      IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/y_id_pipe.sv
// Pipelined decode stage: register file with WB bypass, immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
module y_id_pipe
  import y_id_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_ins,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_imm_type,
  output logic            ex_is_load,
  output logic            ex_reg_write,
  output logic            ex_illegal,
  output logic            hazard
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            use1, use2, wr_rd;
  logic            rs1_ok, rs2_ok, rd_ok, wb_ok;
  logic [XLEN-1:0] rd1, rd2;
  logic [XLEN-1:0] imm;
  imm_type_t       imm_type;
  logic            illegal;
  logic            advance;

  // Indices at or above NREG (bit 4 with RV32E) are not architectural
  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < 6'(NREG);
  endfunction

  assign opcode = if_ins[6:0];
  assign rd     = if_ins[11:7];
  assign rs1    = if_ins[19:15];
  assign rs2    = if_ins[24:20];

  y_id_pipe_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ins      (if_ins),
    .imm      (imm),
    .imm_type (imm_type)
  );

  // Operand classification and legality of the instruction in ID
  always_comb begin
    use1    = uses_rs1(opcode);
    use2    = uses_rs2(opcode);
    wr_rd   = writes_rd(opcode);
    rs1_ok  = idx_ok(rs1);
    rs2_ok  = idx_ok(rs2);
    rd_ok   = idx_ok(rd);
    wb_ok   = idx_ok(wb_rd);
    illegal = !known_op(opcode) || (use1 && !rs1_ok) || (use2 && !rs2_ok) ||
              (wr_rd && !rd_ok);
  end

  // Register reads: x0 and out-of-range indices read 0, a same-cycle WB write wins
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0 && rs1_ok) begin
      if (wb_we && wb_rd == rs1) rd1 = wb_data;
      else                       rd1 = regs[rs1[AW-1:0]];
    end
    if (rs2 != 5'd0 && rs2_ok) begin
      if (wb_we && wb_rd == rs2) rd2 = wb_data;
      else                       rd2 = regs[rs2[AW-1:0]];
    end
  end

  // Load-use stall: the load in EX produces a register the ID instruction reads
  always_comb begin
    advance  = !ex_valid || ex_ready;
    hazard   = ex_valid && ex_is_load && (ex_rd != 5'd0) && if_valid &&
               ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
    id_ready = flush || (advance && !hazard);
  end

  // Register file write port; x0 and non-architectural indices are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0 && wb_ok) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX register: flush beats bubble beats load; otherwise hold for EX
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_opcode    <= '0;
      ex_imm_type  <= '0;
      ex_is_load   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid     <= if_valid;
        ex_pc        <= if_pc;
        ex_rd1       <= rd1;
        ex_rd2       <= rd2;
        ex_imm       <= imm;
        ex_rs1       <= rs1;
        ex_rs2       <= rs2;
        ex_rd        <= rd;
        ex_funct3    <= if_ins[14:12];
        ex_funct7b5  <= if_ins[30];
        ex_opcode    <= opcode;
        ex_imm_type  <= imm_type;
        ex_is_load   <= (opcode == OP_LOAD);
        ex_reg_write <= wr_rd && (rd != 5'd0);
        ex_illegal   <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_y_id_pipe.sv
// Directed bench for the ID stage: expected ID/EX contents are queued when an
// instruction is offered and accepted, and checked while it sits in EX.
module tb_y_id_pipe;

  logic        clk = 1'b0;
  logic        reset, if_valid, wb_we, flush, ex_ready;
  logic [31:0] if_ins, if_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        id_ready, ex_valid, ex_funct7b5, ex_is_load, ex_reg_write, ex_illegal, hazard;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3, ex_imm_type;
  logic [6:0]  ex_opcode;

  logic        e_id_ready, e_ex_valid, e_funct7b5, e_is_load, e_reg_write, e_illegal, e_hazard;
  logic [31:0] e_pc, e_rd1, e_rd2, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [2:0]  e_funct3, e_imm_type;
  logic [6:0]  e_opcode;

  always #5 clk = ~clk;

  y_id_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
    .id_ready(id_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_opcode(ex_opcode), .ex_imm_type(ex_imm_type), .ex_is_load(ex_is_load),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal), .hazard(hazard)
  );

  y_id_pipe #(.XLEN(32), .NREG(16)) dut16 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
    .id_ready(e_id_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(e_ex_valid), .ex_pc(e_pc),
    .ex_rd1(e_rd1), .ex_rd2(e_rd2), .ex_imm(e_imm), .ex_rs1(e_rs1),
    .ex_rs2(e_rs2), .ex_rd(e_rd), .ex_funct3(e_funct3), .ex_funct7b5(e_funct7b5),
    .ex_opcode(e_opcode), .ex_imm_type(e_imm_type), .ex_is_load(e_is_load),
    .ex_reg_write(e_reg_write), .ex_illegal(e_illegal), .hazard(e_hazard)
  );

  typedef struct {
    logic [31:0] ins, pc, rd1, rd2, imm;
    logic [2:0]  it;
    logic        ld, rw, ill;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] pc = 32'h0000_1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] imm,
                              input logic [2:0] it, input logic ld, input logic rw,
                              input logic ill);
    exp_t e;
    e.ins = ins; e.pc = '0; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.it = it; e.ld = ld; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  // One cycle: drive, check comb outputs and EX contents at negedge, clock it in
  task automatic cyc(input logic v, input logic [31:0] ins, input logic fl,
                     input logic er, input logic x_idr, input logic x_haz,
                     input logic x_exv, input exp_t e);
    exp_t f;
    if_valid = v; if_ins = ins; if_pc = pc; flush = fl; ex_ready = er;
    @(negedge clk);
    chk("id_ready", 32'(id_ready), 32'(x_idr));
    chk("hazard", 32'(hazard), 32'(x_haz));
    chk("ex_valid", 32'(ex_valid), 32'(x_exv));
    if (x_exv) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL scoreboard_empty observed=ex_valid expected=queued_entry");
      end else begin
        f = sb[0];
        chk("ex_pc", ex_pc, f.pc);
        chk("ex_rd1", ex_rd1, f.rd1);
        chk("ex_rd2", ex_rd2, f.rd2);
        chk("ex_imm", ex_imm, f.imm);
        chk("ex_imm_type", 32'(ex_imm_type), 32'(f.it));
        chk("ex_fields", {ex_funct7b5, ex_rs2, ex_rs1, ex_funct3, ex_rd, ex_opcode},
            {f.ins[30], f.ins[24:20], f.ins[19:15], f.ins[14:12], f.ins[11:7], f.ins[6:0]});
        chk("ex_flags", 32'({ex_is_load, ex_reg_write, ex_illegal}), 32'({f.ld, f.rw, f.ill}));
        if (er || fl) void'(sb.pop_front());
      end
    end
    if (v && x_idr && !fl) begin
      f = e;
      f.pc = pc;
      sb.push_back(f);
    end
    @(posedge clk);
    #1;
    pc = pc + 32'd4;
  endtask

  localparam logic [31:0] ADD_4_5_6  = 32'h0062_8233;
  localparam logic [31:0] ADDI_1_M1  = 32'hFFF0_0093;
  localparam logic [31:0] SW_2_8_1   = 32'h0020_A423;
  localparam logic [31:0] BEQ_M4     = 32'hFE00_0EE3;
  localparam logic [31:0] LUI_1      = 32'h1234_50B7;
  localparam logic [31:0] JAL_M8     = 32'hFF9F_F06F;
  localparam logic [31:0] ADD_4_3_3  = 32'h0031_8233;
  localparam logic [31:0] ADD_5_0_3  = 32'h0030_02B3;
  localparam logic [31:0] ADD_7_0_0  = 32'h0000_03B3;
  localparam logic [31:0] LW_5_0_1   = 32'h0000_A283;
  localparam logic [31:0] ADD_6_5_0  = 32'h0002_8333;
  localparam logic [31:0] ADDI_8_5   = 32'h0050_0413;
  localparam logic [31:0] ADD_9_8_8  = 32'h0084_04B3;
  localparam logic [31:0] ADD_17_1_2 = 32'h0020_88B3;
  localparam logic [31:0] OP_7F      = 32'h0000_007F;

  initial begin
    exp_t nx;
    nx = mk(32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; if_valid = 1'b0; if_ins = '0; if_pc = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_ex_outputs",
        32'({ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
             ex_funct7b5, ex_opcode, ex_imm_type, ex_is_load, ex_reg_write, ex_illegal} != '0),
        32'd0);
    chk("reset_id_ready", 32'(id_ready), 32'd1);
    reset = 1'b0;

    // Decode sweep with zeroed registers
    cyc(1, ADD_4_5_6, 0, 1, 1, 0, 0, mk(ADD_4_5_6, 0, 0, 0, 3'd0, 0, 1, 0));
    cyc(1, ADDI_1_M1, 0, 1, 1, 0, 1, mk(ADDI_1_M1, 0, 0, 32'hFFFF_FFFF, 3'd1, 0, 1, 0));
    cyc(1, SW_2_8_1,  0, 1, 1, 0, 1, mk(SW_2_8_1, 0, 0, 32'h0000_0008, 3'd2, 0, 0, 0));
    cyc(1, BEQ_M4,    0, 1, 1, 0, 1, mk(BEQ_M4, 0, 0, 32'hFFFF_FFFC, 3'd3, 0, 0, 0));
    cyc(1, LUI_1,     0, 1, 1, 0, 1, mk(LUI_1, 0, 0, 32'h1234_5000, 3'd4, 0, 1, 0));
    cyc(1, JAL_M8,    0, 1, 1, 0, 1, mk(JAL_M8, 0, 0, 32'hFFFF_FFF8, 3'd5, 0, 0, 0));

    // Same-cycle WB bypass, then a dropped write to x0
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    cyc(1, ADD_4_3_3, 0, 1, 1, 0, 1, mk(ADD_4_3_3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 3'd0, 0, 1, 0));
    wb_rd = 5'd0; wb_data = 32'h1234_5678;
    cyc(1, ADD_5_0_3, 0, 1, 1, 0, 1, mk(ADD_5_0_3, 0, 32'hDEAD_BEEF, 0, 3'd0, 0, 1, 0));
    wb_we = 1'b0;
    cyc(1, ADD_7_0_0, 0, 1, 1, 0, 1, mk(ADD_7_0_0, 0, 0, 0, 3'd0, 0, 1, 0));

    // Load-use: one bubble, then the dependent add issues
    cyc(1, LW_5_0_1,  0, 1, 1, 0, 1, mk(LW_5_0_1, 0, 0, 0, 3'd1, 1, 1, 0));
    cyc(1, ADD_6_5_0, 0, 1, 0, 1, 1, nx);
    cyc(1, ADD_6_5_0, 0, 1, 1, 0, 0, mk(ADD_6_5_0, 0, 0, 0, 3'd0, 0, 1, 0));

    // EX back-pressure for three cycles, then flush clears ID and EX
    cyc(1, ADDI_8_5,  0, 1, 1, 0, 1, mk(ADDI_8_5, 0, 0, 32'h0000_0005, 3'd1, 0, 1, 0));
    cyc(1, ADD_9_8_8, 0, 0, 0, 0, 1, nx);
    cyc(1, ADD_9_8_8, 0, 0, 0, 0, 1, nx);
    cyc(1, ADD_9_8_8, 0, 0, 0, 0, 1, nx);
    cyc(1, ADD_9_8_8, 1, 0, 1, 0, 1, nx);
    cyc(0, 32'h0,     0, 1, 1, 0, 0, nx);

    // Flush coinciding with a load-use hazard
    cyc(1, LW_5_0_1,  0, 1, 1, 0, 0, mk(LW_5_0_1, 0, 0, 0, 3'd1, 1, 1, 0));
    cyc(1, ADD_6_5_0, 1, 1, 1, 1, 1, nx);
    cyc(0, 32'h0,     0, 1, 1, 0, 0, nx);

    // Register range and unknown opcode (RV32E instance alongside)
    cyc(1, ADD_17_1_2, 0, 1, 1, 0, 0, mk(ADD_17_1_2, 0, 0, 0, 3'd0, 0, 1, 0));
    chk("rv32e_x17_illegal", 32'(e_illegal), 32'd1);
    cyc(1, OP_7F,      0, 1, 1, 0, 1, mk(OP_7F, 0, 0, 0, 3'd0, 0, 0, 1));
    chk("rv32e_op7f_illegal", 32'(e_illegal), 32'd1);
    chk("rv32e_op7f_imm_type", 32'(e_imm_type), 32'd0);
    cyc(0, 32'h0,      0, 1, 1, 0, 1, nx);
    cyc(0, 32'h0,      0, 1, 1, 0, 0, nx);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
